counter_ctrl: RTL
=================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run one count sequence; sampled only in IDLE.
REQ-005 start_val  input  8  preset to load into the counter; captured when start is accepted.
REQ-006 stop_val  input  8  terminal value; captured when start is accepted.
REQ-007 pause  input  1  while high in COUNT, holds the counter (cnt_en low).
REQ-008 abort  input  1  terminates a running sequence without done.
REQ-009 cnt_in  input  8  current value of the controlled counter.
REQ-010 cnt_load  output  1  load strobe to the counter.
REQ-011 cnt_en  output  1  count-enable to the counter.
REQ-012 cnt_data  output  8  load data to the counter; equals captured start_val.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 remaining  output  8  (stop_reg - cnt_in) mod 256 in COUNT; 0 otherwise.

Function
REQ-016 Controlled counter contract: on each clk edge, load -> cnt=data; else en -> cnt=(cnt+1) mod 256; else hold.
REQ-017 FSM states SHALL be IDLE, LOAD, COUNT, DONE.
REQ-018 IDLE: start=1 -> LOAD next edge, with start_val/stop_val captured into start_reg/stop_reg on that edge; otherwise stay.
REQ-019 LOAD: cnt_load=1, cnt_en=0 for exactly one cycle; -> COUNT unconditionally (unless abort/rst).
REQ-020 COUNT: cnt_en = !pause && !abort && (cnt_in != stop_reg), combinational.
REQ-021 COUNT: cnt_in == stop_reg -> DONE next edge; pause does not block this transition.
REQ-022 DONE: done=1 for one cycle; -> IDLE next edge.
REQ-023 cnt_load and cnt_en SHALL never be high in the same cycle, and both are 0 in IDLE and DONE.
REQ-024 Enable cycles per sequence SHALL equal (stop_val - start_val) mod 256 (wrap 255->0 is legal); start_val == stop_val gives zero enable cycles.
REQ-025 Latency without pause: start sampled at edge k -> LOAD in cycle k+1, COUNT from k+2, done high in cycle k+3+N, where N = enable count.
REQ-026 Each pause-high cycle in COUNT while cnt_in != stop_reg SHALL delay done by exactly one cycle.
REQ-027 start while busy (LOAD/COUNT/DONE) SHALL be ignored; start_reg/stop_reg stay unchanged.
REQ-028 abort in LOAD or COUNT: cnt_load/cnt_en forced 0 that cycle; -> IDLE next edge; done not asserted.
REQ-029 abort in DONE SHALL not suppress the done pulse; abort in IDLE has priority over start (start ignored).
REQ-030 start_val/stop_val changes after acceptance SHALL not affect the running sequence.

Reset
REQ-031 rst=1 at an edge SHALL force state IDLE, start_reg=0, stop_reg=0.
REQ-032 During and after reset: cnt_load=0, cnt_en=0, cnt_data=0, busy=0, done=0, remaining=0.
REQ-033 rst SHALL take priority over start, abort and every state transition, including mid-sequence.
REQ-034 The block does not reset the controlled counter; cnt_in is not modified by the controller's reset.

Verification
REQ-035 start_val=100, stop_val=110 at edge k -> cnt_load one cycle (k+1) with cnt_data=100, 10 cnt_en cycles, done only in cycle k+13, busy low from k+14.
REQ-036 start_val=250, stop_val=4 -> 10 enable cycles, cnt_in sequence 250..255,0..4, remaining 10 down to 0, done at k+13.
REQ-037 start_val=stop_val=42 -> one load, zero cnt_en cycles, done at k+3.
REQ-038 100->110 with pause high for 3 cycles mid-COUNT -> cnt_en low exactly those 3 cycles, done at k+16; start pulsed while busy is ignored.
REQ-039 abort at cnt_in=105 in COUNT -> no cnt_en that cycle, IDLE next edge, no done; new start then runs normally.
REQ-040 rst asserted in COUNT -> all outputs 0 next cycle, state IDLE; start after rst release is accepted.

Source files
------------

// File: rtl/counter_ctrl.sv
// Sequencer for an external 8-bit counter: loads a preset, enables counting
// up to a captured terminal value, then pulses done. Supports pause and abort.
module counter_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] start_val,
  input  logic [7:0] stop_val,
  input  logic       pause,
  input  logic       abort,
  input  logic [7:0] cnt_in,
  output logic       cnt_load,
  output logic       cnt_en,
  output logic [7:0] cnt_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] start_reg;
  logic [7:0] stop_reg;
  logic       at_stop;

  assign at_stop = (cnt_in == stop_reg);

  // NOTE: sequential state uses <= only; the synchronous reset is the first
  // branch so it overrides start, abort and every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_reg <= 8'd0;
      stop_reg  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          // abort in IDLE wins over start
          if (start && !abort) begin
            state     <= LOAD;
            start_reg <= start_val;
            stop_reg  <= stop_val;
          end
        end
        LOAD:    state <= abort ? IDLE : COUNT;
        COUNT: begin
          if (abort)        state <= IDLE;
          else if (at_stop) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes depend on live pause/abort/cnt_in, so they are decoded here;
  // rst gates every output low while it is held.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_data  = 8'd0;
    busy      = 1'b0;
    done      = 1'b0;
    remaining = 8'd0;
    if (!rst) begin
      cnt_data = start_reg;
      busy     = (state != IDLE);
      unique case (state)
        LOAD:  cnt_load = !abort;
        COUNT: begin
          cnt_en    = !pause && !abort && !at_stop;
          remaining = stop_reg - cnt_in;
        end
        DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
